// File: rtl/mba_dot_accumulator.sv
// Saturating dot-product accumulator for the Booth multiplier's 16-bit signed products.
// Sums frames of Len products and presents each result on a valid/ready handshake.
module mba_dot_accumulator #(
    parameter int unsigned Len  = 8,
    parameter int unsigned AccW = 24
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [15:0]     in_prod_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [AccW-1:0] out_sum_o,
    output logic            out_sat_o
);

    localparam logic [7:0]      LastCount = 8'(Len - 1);
    localparam logic [AccW-1:0] AccMax    = {1'b0, {(AccW-1){1'b1}}};
    localparam logic [AccW-1:0] AccMin    = {1'b1, {(AccW-1){1'b0}}};

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e          state_q, state_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [7:0]      count_q, count_d;
    logic            sat_q, sat_d;
    logic [AccW-1:0] out_sum_q, out_sum_d;
    logic            out_sat_q, out_sat_d;

    logic            in_accept;
    logic            last_prod;
    logic [AccW:0]   acc_ext;
    logic [AccW:0]   prod_ext;
    logic [AccW:0]   sum_ext;
    logic [AccW-1:0] acc_next;
    logic            sat_hit;

    assign in_accept = in_valid_i && (state_q == StAccum);
    assign last_prod = (count_q == LastCount);

    // One guard bit is enough: the top two bits disagree exactly on overflow.
    always_comb begin
        acc_ext  = {acc_q[AccW-1], acc_q};
        prod_ext = {{(AccW+1-16){in_prod_i[15]}}, in_prod_i};
        sum_ext  = acc_ext + prod_ext;
        acc_next = sum_ext[AccW-1:0];
        sat_hit  = 1'b0;
        if (!sum_ext[AccW] && sum_ext[AccW-1]) begin
            acc_next = AccMax;
            sat_hit  = 1'b1;
        end else if (sum_ext[AccW] && !sum_ext[AccW-1]) begin
            acc_next = AccMin;
            sat_hit  = 1'b1;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        count_d   = count_q;
        sat_d     = sat_q;
        out_sum_d = out_sum_q;
        out_sat_d = out_sat_q;
        if (in_accept) begin
            if (last_prod) begin
                out_sum_d = acc_next;
                out_sat_d = sat_q | sat_hit;
                acc_d     = '0;
                count_d   = '0;
                sat_d     = 1'b0;
            end else begin
                acc_d   = acc_next;
                count_d = count_q + 8'd1;
                sat_d   = sat_q | sat_hit;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (in_accept && last_prod) state_d = StHold;
            StHold:  if (out_ready_i)            state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == StAccum);
        out_valid_o = (state_q == StHold);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            out_sum_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            out_sum_q <= out_sum_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sum_o = out_sum_q;
    assign out_sat_o = out_sat_q;

endmodule

// File: tb/tb_mba_dot_accumulator.sv
// Bench for mba_dot_accumulator: directed frames plus random traffic, every cycle
// compared against an integer-arithmetic frame model.
module tb_mba_dot_accumulator;

    localparam int LEN   = 4;
    localparam int ACC_W = 17;
    localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
    localparam int MINV  = -(1 << (ACC_W - 1));

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;

    int n_vec;
    int n_err;

    // Reference model state
    bit m_hold;
    int m_acc;
    int m_cnt;
    bit m_sat;
    int m_sum;
    bit m_osat;

    mba_dot_accumulator #(
        .Len (LEN),
        .AccW(ACC_W)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_prod_i  (in_prod),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum),
        .out_sat_o  (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(logic [ACC_W-1:0] v);
        return {{(32-ACC_W){v[ACC_W-1]}}, v};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_acc = 0; m_cnt = 0; m_sat = 0; m_sum = 0; m_osat = 0;
    endtask

    // One clock: drive inputs, compare at the falling edge, then advance the model.
    task automatic cycle(input bit r, input bit v, input int p, input bit o);
        int s;
        rst       = r;
        in_valid  = v;
        in_prod   = 16'(p);
        out_ready = o;
        @(negedge clk);
        check("in_ready", int'(in_ready), int'(!m_hold));
        check("out_valid", int'(out_valid), int'(m_hold));
        check("out_sum", sx(out_sum), m_sum);
        check("out_sat", int'(out_sat), int'(m_osat));
        if (r) begin
            model_reset();
        end else if (!m_hold && v) begin
            s = m_acc + p;
            if (s > MAXV) begin s = MAXV; m_sat = 1; end
            if (s < MINV) begin s = MINV; m_sat = 1; end
            m_cnt++;
            if (m_cnt == LEN) begin
                m_sum = s; m_osat = m_sat; m_hold = 1;
                m_acc = 0; m_cnt = 0; m_sat = 0;
            end else begin
                m_acc = s;
            end
        end else if (m_hold && o) begin
            m_hold = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int p0, input int p1, input int p2, input int p3, input bit o);
        cycle(0, 1, p0, o);
        cycle(0, 1, p1, o);
        cycle(0, 1, p2, o);
        cycle(0, 1, p3, o);
    endtask

    initial begin
        int p;
        n_vec = 0;
        n_err = 0;
        rst = 1; in_valid = 0; in_prod = '0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", sx(out_sum), 0);
        check("rst_out_sat", int'(out_sat), 0);

        // Basic frame
        frame(1, 2, 3, 4, 1);
        check("basic_valid", int'(out_valid), 1);
        check("basic_ready", int'(in_ready), 0);
        check("basic_sum", sx(out_sum), 10);
        check("basic_sat", int'(out_sat), 0);
        cycle(0, 0, 0, 1);
        check("basic_ready_back", int'(in_ready), 1);

        // Signed mix with gaps
        cycle(0, 1, -300, 1); cycle(0, 0, 7, 1);
        cycle(0, 1, 81, 1);   cycle(0, 0, 7, 1);
        cycle(0, 1, -1, 1);   cycle(0, 0, 7, 1);
        cycle(0, 1, 20, 1);
        check("gaps_sum", sx(out_sum), -200);
        cycle(0, 0, 0, 1);

        // Backpressure: product 99 must not leak into the held or next frame
        frame(10, 20, 30, 40, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 99, 0);
            check("bp_sum", sx(out_sum), 100);
            check("bp_ready", int'(in_ready), 0);
        end
        cycle(0, 0, 0, 1);
        frame(1, 1, 1, 1, 1);
        check("bp_next_sum", sx(out_sum), 4);
        cycle(0, 0, 0, 1);

        // Saturation in both directions, then a clean frame
        frame(32767, 32767, 32767, 32767, 1);
        check("sat_pos_sum", sx(out_sum), MAXV);
        check("sat_pos_flag", int'(out_sat), 1);
        cycle(0, 0, 0, 1);
        frame(-32768, -32768, -32768, -32768, 1);
        check("sat_neg_sum", sx(out_sum), MINV);
        check("sat_neg_flag", int'(out_sat), 1);
        cycle(0, 0, 0, 1);
        // Saturate early then come back down: clamping happens at every add
        frame(32767, 32767, 32767, -32768, 1);
        check("sat_mid_sum", sx(out_sum), MAXV - 32768);
        check("sat_mid_flag", int'(out_sat), 1);
        cycle(0, 0, 0, 1);
        frame(1, 1, 1, 1, 1);
        check("sat_clear_sum", sx(out_sum), 4);
        check("sat_clear_flag", int'(out_sat), 0);
        cycle(0, 0, 0, 1);

        // Reset mid-frame
        cycle(0, 1, 5, 1);
        cycle(0, 1, 5, 1);
        cycle(1, 0, 0, 1);
        frame(1, 1, 1, 1, 1);
        check("rst_mid_sum", sx(out_sum), 4);
        cycle(0, 0, 0, 1);

        // Reset during HOLD drops the result
        frame(2, 2, 2, 2, 0);
        cycle(1, 1, 3, 1);
        check("rst_hold_valid", int'(out_valid), 0);
        check("rst_hold_ready", int'(in_ready), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3))
                0:       p = 32767;
                1:       p = -32768;
                default: p = int'($signed(16'($urandom)));
            endcase
            cycle(($urandom_range(63) == 0), bit'($urandom_range(1)), p,
                  bit'($urandom_range(3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mba_dot_accumulator.md
# mba_dot_accumulator

Downstream consumer of the Modified Booth multiplier's 16-bit signed product. It accepts a stream of products over a valid/ready handshake and sums a frame of LEN products into a saturating signed accumulator. Each completed dot-product result is presented on a second valid/ready handshake. It lets the multiplier datapath compute vector dot products (FIR taps, matrix rows) without software summation.

## Interface
- LEN, 8, products per frame; legal range 1..255
- ACC_W, 24, accumulator and result width in bits, signed; must be ≥ 16
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is high
- in_valid  input  1  in_prod is valid this cycle
- in_ready  output  1  block can accept a product this cycle
- in_prod  input  16  signed two's-complement product from the multiplier
- out_valid  output  1  out_sum/out_sat hold a completed frame result
- out_ready  input  1  downstream accepts the result this cycle
- out_sum  output  ACC_W  signed saturated frame sum
- out_sat  output  1  sticky flag: saturation occurred at least once during this frame

## Operation
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset:
  - state=ACCUM, acc=0, count=0, sat=0.
  - Outputs: in_ready=1, out_valid=0, out_sum=0, out_sat=0.
- Input accept: occurs on a cycle with in_valid && in_ready.
  - in_prod is sign-extended to ACC_W+1 bits and added to acc (also sign-extended).
  - If the sum > 2^(ACC_W-1)-1, acc takes the max positive value and sat is set.
  - If the sum < -2^(ACC_W-1), acc takes the min negative value and sat is set.
  - Otherwise acc takes the sum.
  - Saturation is applied at every add, not only at frame end.
- count increments on each accept.
- Frame end: the accept that occurs with count==LEN-1.
  - Final acc and sat are loaded into out_sum/out_sat.
  - state becomes HOLD.
  - count, acc and sat are cleared for the next frame.
- HOLD:
  - out_sum and out_sat stay stable until the output handshake.
  - in_prod is ignored because in_ready=0.
- Output accept: occurs on a cycle with out_valid && out_ready; state returns to ACCUM.
  - out_sum/out_sat keep their last values after the handshake; they are valid only while out_valid=1.
- in_valid while in_ready=0: no effect. The upstream must hold the product until it is accepted.
- LEN=1: every accepted product forms a complete frame.

## Timing
- in_ready is a pure function of state and is registered. It never depends combinationally on in_valid or out_ready.
- Result latency: out_valid rises on the clock edge that accepts the LEN-th product and is visible in the following cycle.
- Return to ACCUM: in_ready rises in the cycle after the output handshake. No product is accepted in the handshake cycle itself.
- Throughput: LEN+1 cycles per frame minimum, when out_ready is held high.
- Backpressure: if out_ready=0, HOLD persists indefinitely with outputs stable.
- reset has priority over every handshake.
  - Reset mid-frame discards the partial sum and count.
  - Reset during HOLD drops the pending result: out_valid=0 the next cycle, and no handshake is honoured in the reset cycle.
- No combinational path from any input to any output.

## Test plan
- **Reset**: with LEN=4, ACC_W=24, assert reset for 2 cycles. Require in_ready=1, out_valid=0, out_sum=0, out_sat=0.
- **Basic frame**: LEN=4, out_ready=1, products 1,2,3,4 on consecutive cycles.
  - out_valid=1 exactly one cycle after the 4th accept, with out_sum=10 and out_sat=0.
  - in_ready=0 for exactly one cycle.
- **Signed mix with gaps**: LEN=4, in_valid toggled every other cycle, products -300, 81, -1, 20.
  - out_sum=-200 (24'hFFFF38).
  - Only in_valid&&in_ready cycles advance count.
- **Backpressure**: complete a frame with out_ready=0 for 5 cycles, while also driving in_valid=1 with product 99.
  - out_sum stays stable for all 5 cycles.
  - in_ready=0 throughout; product 99 is not accumulated.
  - After out_ready=1, the next frame starts from 0.
- **Saturation**: LEN=8, ACC_W=18.
  - Eight products of 32767 give out_sum=131071 and out_sat=1.
  - Eight products of -32768 give out_sum=-131072 and out_sat=1.
  - A following frame of eight 1s gives out_sum=8 and out_sat=0.
- **Reset mid-operation**:
  - LEN=4: accept 5,5, assert reset, then send 1,1,1,1. Require out_sum=4.
  - Assert reset during HOLD. Require out_valid=0 the next cycle.
